// File: rtl/serial_adder_if.sv
// Handshake/result bundle for serial_adder: request side (start, operands) and
// registered result side (busy, done, sum, carries, flags).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] cout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout, zero, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout, zero, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop, one bit per clock.
// Optional zero/ovf flag logic is built only when SERIAL_ADDER_FLAGS_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_a, r_b, r_cout;
  logic [WIDTH:0]   r_s;
  logic             r_c;
  logic [IW-1:0]    r_idx;
  logic             r_busy, r_done;

  logic             w_accept, w_last;
  logic             w_ai, w_bi, w_sum, w_cy;
  logic [WIDTH-1:0] w_s_low, w_cout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // DONE also samples start so a request held high is taken at E_WIDTH+1,
  // giving one operation per WIDTH+1 cycles.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_accept  = 1'b1;
        w_state_n = RUN;
      end
      RUN:  if (w_last) w_state_n = DONE;
      DONE: begin
        if (bus.start) begin
          w_accept  = 1'b1;
          w_state_n = RUN;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_last   = (r_idx == IW'(WIDTH - 1));
    w_ai     = r_a[r_idx];
    w_bi     = r_b[r_idx];
    w_sum    = w_ai ^ w_bi ^ r_c;
    w_cy     = (w_ai & w_bi) | (r_c & (w_ai ^ w_bi));
    w_s_low  = r_s[WIDTH-1:0];
    w_cout_n = r_cout;
    w_s_low[r_idx]  = w_sum;
    w_cout_n[r_idx] = w_cy;
  end

`ifdef SERIAL_ADDER_FLAGS_EN
  logic r_zero, r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_idx  <= '0;
      r_s    <= '0;
      r_cout <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_n != IDLE);
      r_done <= (w_state_n == DONE);
      if (w_accept) begin
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_c    <= bus.cin;
        r_idx  <= '0;
        r_s    <= '0;
        r_cout <= '0;
`ifdef SERIAL_ADDER_FLAGS_EN
        r_zero <= 1'b0;
        r_ovf  <= 1'b0;
`endif
      end else if (r_state == RUN) begin
        r_s[WIDTH-1:0] <= w_s_low;
        r_cout         <= w_cout_n;
        r_c            <= w_cy;
        r_idx          <= r_idx + 1'b1;
        if (w_last) begin
          r_s[WIDTH] <= w_cy;
`ifdef SERIAL_ADDER_FLAGS_EN
          r_zero <= (w_s_low == '0);
          r_ovf  <= w_cout_n[WIDTH-1] ^ w_cout_n[WIDTH-2];
`endif
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADDER_FLAGS_EN
  assign bus.zero = r_zero;
  assign bus.ovf  = r_ovf;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); flag expectations
// follow SERIAL_ADDER_FLAGS_EN.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef SERIAL_ADDER_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns 1 time unit after the accept edge E0.
  task automatic do_start(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    bus.a = ta; bus.b = tb_; bus.cin = tc; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen at a negedge; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done === 1'b1) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.s !== 9'h000) begin failures++; $display("FAIL reset_s got=%h exp=000", bus.s); end
    checks++; if (bus.cout !== 8'h00) begin failures++; $display("FAIL reset_cout got=%h exp=00", bus.cout); end
    checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {bus.zero, bus.ovf}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    do_start(8'h35, 8'h4A, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", bus.busy); end
    wait_done(cyc);
    checks++; if (cyc !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", cyc); end
    checks++; if (bus.s !== 9'h07F) begin failures++; $display("FAIL basic_s got=%h exp=07f", bus.s); end
    checks++; if (bus.cout !== 8'h00) begin failures++; $display("FAIL basic_cout got=%h exp=00", bus.cout); end
    checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {bus.zero, bus.ovf}); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%b exp=0", bus.busy); end
    checks++; if (bus.s !== 9'h07F) begin failures++; $display("FAIL basic_s_hold got=%h exp=07f", bus.s); end
    @(negedge clk);
  endtask

  task automatic test_flags;
    int cyc;
    do_start(8'hFF, 8'h01, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 8) begin failures++; $display("FAIL carry_latency got=%0d exp=8", cyc); end
    checks++; if (bus.s !== 9'h100) begin failures++; $display("FAIL carry_s got=%h exp=100", bus.s); end
    checks++; if (bus.cout !== 8'hFF) begin failures++; $display("FAIL carry_cout got=%h exp=ff", bus.cout); end
    checks++; if (bus.zero !== FL) begin failures++; $display("FAIL carry_zero got=%b exp=%b", bus.zero, FL); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL carry_ovf got=%b exp=0", bus.ovf); end
    @(negedge clk);
    do_start(8'h7F, 8'h01, 1'b0);
    checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin failures++; $display("FAIL flags_clear_on_accept got=%b exp=00", {bus.zero, bus.ovf}); end
    wait_done(cyc);
    checks++; if (bus.s !== 9'h080) begin failures++; $display("FAIL ovf_s got=%h exp=080", bus.s); end
    checks++; if (bus.cout !== 8'h7F) begin failures++; $display("FAIL ovf_cout got=%h exp=7f", bus.cout); end
    checks++; if (bus.ovf !== FL) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", bus.ovf, FL); end
    checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL ovf_zero got=%b exp=0", bus.zero); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    do_start(8'hFF, 8'hFF, 1'b1);
    wait_done(cyc);
    checks++; if (bus.s !== 9'h1FF) begin failures++; $display("FAIL max_s got=%h exp=1ff", bus.s); end
    checks++; if (bus.cout !== 8'hFF) begin failures++; $display("FAIL max_cout got=%h exp=ff", bus.cout); end
    // start raised during DONE; accept edge is E9
    do_start(8'h0F, 8'h10, 1'b1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_accept_done got=%b exp=0", bus.done); end
    wait_done(cyc);
    checks++; if (cyc !== 8) begin failures++; $display("FAIL b2b_latency got=%0d exp=8", cyc); end
    checks++; if (bus.s !== 9'h020) begin failures++; $display("FAIL b2b_s got=%h exp=020", bus.s); end
    checks++; if (bus.cout !== 8'h1F) begin failures++; $display("FAIL b2b_cout got=%h exp=1f", bus.cout); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int ndone;
    int first;
    ndone = 0; first = -1;
    do_start(8'h12, 8'h34, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done === 1'b1) begin ndone++; if (first < 0) first = k; end
      if (k == 3) begin bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; end
      if (k == 4) bus.start = 1'b0;
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (first !== 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", first); end
    checks++; if (bus.s !== 9'h046) begin failures++; $display("FAIL ignore_s got=%h exp=046", bus.s); end
    checks++; if (bus.cout !== 8'h30) begin failures++; $display("FAIL ignore_cout got=%h exp=30", bus.cout); end
  endtask

  task automatic test_reset_midop;
    int cyc;
    @(negedge clk);
    do_start(8'hF0, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.s !== 9'h000) begin failures++; $display("FAIL midrst_s got=%h exp=000", bus.s); end
    checks++; if (bus.cout !== 8'h00) begin failures++; $display("FAIL midrst_cout got=%h exp=00", bus.cout); end
    checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin failures++; $display("FAIL midrst_flags got=%b exp=00", {bus.zero, bus.ovf}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    do_start(8'h01, 8'h01, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 8) begin failures++; $display("FAIL postrst_latency got=%0d exp=8", cyc); end
    checks++; if (bus.s !== 9'h002) begin failures++; $display("FAIL postrst_s got=%h exp=002", bus.s); end
    checks++; if (bus.cout !== 8'h01) begin failures++; $display("FAIL postrst_cout got=%h exp=01", bus.cout); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_ignore_start();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
